conv_2x2_sched: RTL and testbench
=================================

// Module: conv_2x2_sched
// PURPOSE
//  Frame-level controller for conv_core_2x2. Accepts a row-major 8-bit pixel stream and buffers one row.
//  Forms every 2x2 window (stride 1, no padding) and drives it to the core with the frame's filter.
//  Collects conv_out and emits one 16-bit result per window, in raster order.
//  Sits between the pixel source (DMA/bus side) and the convolution datapath.
// PARAMETERS
//  IMG_W     8  pixels per row (>=2)
//  IMG_H     8  rows per frame (>=2)
//  CORE_LAT  1  cycles from core_image/core_filter update to valid core_conv_out
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   reset, synchronous, active-low
//  start          in   1   begin frame; sampled only in IDLE
//  filter_in      in   32  {f_tl,f_tr,f_bl,f_br}, latched on accepted start
//  busy           out  1   high whenever state != IDLE
//  done           out  1   1-cycle pulse after last result of frame
//  pix_valid      in   1   pixel stream valid
//  pix_ready      out  1   pixel stream ready (high only in RUN)
//  pix_data       in   8   pixel, unsigned
//  core_image     out  32  window {tl,tr,bl,br} to conv_core_2x2.image
//  core_filter    out  32  latched filter to conv_core_2x2.filter
//  core_conv_out  in   16  conv_core_2x2.conv_out
//  res_valid      out  1   result valid; no backpressure, sink must accept
//  res_data       out  16  result, core value passed unmodified
//  res_last       out  1   with res_valid: final window of frame
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, counters=0, valid pipe cleared.
//   All outputs 0: busy, done, pix_ready, core_image, core_filter, res_*.
//   Line buffer contents are don't-care.
//  FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE:
//   IDLE: start=1 -> latch filter_in into core_filter, col=row=0, go RUN.
//   RUN: pix_ready=1. On accept (pix_valid&pix_ready) at (row,col):
//    if row>=1 && col>=1, register core_image={lb[col-1],lb[col],prev_pix,pix_data} and push issue bit.
//    Then lb[col]<=pix_data, prev_pix<=pix_data.
//    col wraps at IMG_W-1 -> 0 with row++.
//    Accept at (IMG_H-1,IMG_W-1) -> DRAIN.
//   DRAIN: pix_ready=0; stay until result carrying res_last is emitted, then DONE.
//   DONE: done=1 for one cycle -> IDLE.
//  Row 0 and column 0 pixels produce no window. Exactly (IMG_W-1)*(IMG_H-1) results per frame.
//  No accept: core_image holds; stream stalls freely (pix_valid gaps allowed).
//  Latency: accept in cycle 0.
//   -> core_image valid in cycle 1.
//   -> core_conv_out sampled at end of cycle CORE_LAT+1.
//   -> res_valid/res_data registered, high in cycle CORE_LAT+2.
//   Full throughput, 1 result/cycle.
//  Issue pipe: CORE_LAT+1 stages of {valid,last}; tail drives res_valid/res_last. Unused stages stay 0.
//  start while busy: ignored. filter_in changes after start: ignored until next frame.
//  start with pix_valid in the same IDLE cycle: pixel not accepted (pix_ready=0).
//  Reset mid-frame: next cycle IDLE, all outputs 0. In-flight results dropped (no res_valid).
//   Next start begins a clean frame.
//  Back-to-back frames: line buffer not cleared; row 0 rewrites it before any use.
//  Arithmetic: no computation here; window order MSB->LSB = tl,tr,bl,br for image and filter.
// STRUCTURE
//  conv_pkg:
//   PIX_W=8, WIN_W=32, ACC_W=16
//   state enum {IDLE,RUN,DRAIN,DONE}
//   function pack_win(tl,tr,bl,br)
//  Sub-module conv_line_buf: IMG_W x 8 single-row buffer.
//   Combinational read of col and col-1 (col-1 via registered previous-read), write at col on accept.
//   Read returns the old value when read and write hit the same address in one cycle.
//  Top: FSM, col/row counters ($clog2 widths), prev_pix reg, issue/last shift pipe, output regs.
// TESTING (bench instantiates real conv_core_2x2, CORE_LAT=1)
//  1. W=H=2, filter {1,2,1,0}, pixels 1,2,3,4
//     -> single res_data=8 with res_last=1; done pulse in the cycle after.
//  2. W=H=3, filter {1,1,1,1}, pixels 1..9
//     -> res_data 12,16,24,28 in order; res_last only on 28; exactly 4 res_valid.
//  3. Test 2 with random pix_valid gaps -> identical results.
//     pix_ready=0 in IDLE/DRAIN/DONE; no accept there.
//  4. start pulsed mid-frame with filter_in={0,0,0,0}
//     -> ignored; results unchanged; busy stays 1 until DONE.
//  5. rst_n=0 after 5 pixels of a 3x3 frame
//     -> next cycle busy=0, res_valid never asserts; re-run of test 2 passes.
//  6. Two back-to-back 3x3 frames (1..9 then 9..1, filter {1,0,0,1})
//     -> frame 2 yields 14,12,8,6; no stale data from frame 1.

Source files
------------

// File: rtl/conv_2x2_sched_pkg.sv
// Shared types and helpers for the 2x2 convolution frame scheduler.
//   PIX_W : pixel width
//   WIN_W : packed 2x2 window / filter width
//   ACC_W : core result width
package conv_2x2_sched_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned WIN_W = 32;
    localparam int unsigned ACC_W = 16;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    // Window packing order, MSB -> LSB: top-left, top-right, bottom-left, bottom-right.
    function automatic logic [WIN_W-1:0] pack_win(input logic [PIX_W-1:0] tl,
                                                   input logic [PIX_W-1:0] tr,
                                                   input logic [PIX_W-1:0] bl,
                                                   input logic [PIX_W-1:0] br);
        return {tl, tr, bl, br};
    endfunction

endpackage

// File: rtl/conv_2x2_sched_line_buf.sv
// Single-row pixel buffer (IMG_W x PIX_W) for the 2x2 scheduler.
//   clk, rst_n  : clock, synchronous active-low reset (read-history register only)
//   col_i       : current column
//   we_i        : write enable (pixel accepted)
//   wdata_i     : pixel written at col_i
//   rd_cur_o    : combinational read of col_i (value from previous row)
//   rd_prev_o   : value read at the previous write, i.e. previous row at col_i-1
module conv_2x2_sched_line_buf
    import conv_2x2_sched_pkg::*;
#(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned CW    = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CW-1:0]    col_i,
    input  logic             we_i,
    input  logic [PIX_W-1:0] wdata_i,
    output logic [PIX_W-1:0] rd_cur_o,
    output logic [PIX_W-1:0] rd_prev_o
);

    logic [PIX_W-1:0] mem_q [IMG_W];
    logic [PIX_W-1:0] prev_q;

    // Read happens before the clocked write, so same-address read sees the old row.
    assign rd_cur_o  = mem_q[col_i];
    assign rd_prev_o = prev_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[col_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else if (we_i) begin
            prev_q <= mem_q[col_i];
        end
    end

endmodule

// File: rtl/conv_2x2_sched.sv
// Frame-level controller for conv_core_2x2: buffers one row of a raster pixel stream,
// forms every 2x2 window (stride 1), drives it to the core and returns one result per window.
//   clk, rst_n        : clock, synchronous active-low reset
//   start, filter_in  : frame start (IDLE only) and filter latched with it
//   busy, done        : frame in progress / one-cycle end-of-frame pulse
//   pix_valid/ready/data : input pixel stream
//   core_image/filter : window and filter towards the core
//   core_conv_out     : core result, valid CORE_LAT cycles after core_image
//   res_valid/data/last : result stream, no backpressure
module conv_2x2_sched
    import conv_2x2_sched_pkg::*;
#(
    parameter int unsigned IMG_W    = 8,
    parameter int unsigned IMG_H    = 8,
    parameter int unsigned CORE_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIN_W-1:0] filter_in,
    output logic             busy,
    output logic             done,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    output logic [WIN_W-1:0] core_image,
    output logic [WIN_W-1:0] core_filter,
    input  logic [ACC_W-1:0] core_conv_out,
    output logic             res_valid,
    output logic [ACC_W-1:0] res_data,
    output logic             res_last
);

    localparam int unsigned CW   = $clog2(IMG_W);
    localparam int unsigned RW   = $clog2(IMG_H);
    localparam int unsigned PIPE = CORE_LAT + 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_e           state_q;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic [PIX_W-1:0] prev_pix_q;
    logic [PIPE-1:0]  pipe_v_q, pipe_l_q;
    logic             busy_q, done_q, pix_ready_q, res_valid_q, res_last_q;
    logic [WIN_W-1:0] core_image_q, core_filter_q;
    logic [ACC_W-1:0] res_data_q;

    logic             accept, issue, issue_last;
    logic [PIX_W-1:0] lb_cur, lb_prev;

    assign accept     = (state_q == StRun) && pix_valid && pix_ready_q;
    // Row 0 and column 0 only fill history; every later pixel closes a window.
    assign issue      = accept && (row_q != '0) && (col_q != '0);
    assign issue_last = issue && (row_q == ROW_LAST) && (col_q == COL_LAST);

    conv_2x2_sched_line_buf #(
        .IMG_W (IMG_W),
        .CW    (CW)
    ) u_line_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_i     (col_q),
        .we_i      (accept),
        .wdata_i   (pix_data),
        .rd_cur_o  (lb_cur),
        .rd_prev_o (lb_prev)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            col_q         <= '0;
            row_q         <= '0;
            prev_pix_q    <= '0;
            pipe_v_q      <= '0;
            pipe_l_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pix_ready_q   <= 1'b0;
            core_image_q  <= '0;
            core_filter_q <= '0;
            res_valid_q   <= 1'b0;
            res_last_q    <= 1'b0;
            res_data_q    <= '0;
        end else begin
            done_q      <= 1'b0;
            // Issue pipe shifts every cycle; its tail lines up with core_conv_out.
            pipe_v_q    <= (pipe_v_q << 1) | PIPE'(issue);
            pipe_l_q    <= (pipe_l_q << 1) | PIPE'(issue_last);
            res_valid_q <= pipe_v_q[PIPE-1];
            res_last_q  <= pipe_l_q[PIPE-1];
            if (pipe_v_q[PIPE-1]) begin
                res_data_q <= core_conv_out;
            end

            case (state_q)
                StIdle: begin
                    if (start) begin
                        core_filter_q <= filter_in;
                        col_q         <= '0;
                        row_q         <= '0;
                        state_q       <= StRun;
                        busy_q        <= 1'b1;
                        pix_ready_q   <= 1'b1;
                    end
                end
                StRun: begin
                    if (accept) begin
                        if (issue) begin
                            core_image_q <= pack_win(lb_prev, lb_cur, prev_pix_q, pix_data);
                        end
                        prev_pix_q <= pix_data;
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                state_q     <= StDrain;
                                pix_ready_q <= 1'b0;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (res_valid_q && res_last_q) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pix_ready   = pix_ready_q;
    assign core_image  = core_image_q;
    assign core_filter = core_filter_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_last    = res_last_q;

endmodule

// File: tb/tb_conv_2x2_sched.sv
// Bench for conv_2x2_sched: a 2x2 and a 3x3 instance, each paired with a one-cycle
// multiply-accumulate core model.
module tb_conv_2x2_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic        rst_n;
    logic        start2, busy2, done2, pv2, pr2, rv2, rl2;
    logic [31:0] filt2, img2, fil2;
    logic [7:0]  pd2;
    logic [15:0] core2, rd2;
    logic        start3, busy3, done3, pv3, pr3, rv3, rl3;
    logic [31:0] filt3, img3, fil3;
    logic [7:0]  pd3;
    logic [15:0] core3, rd3;

    conv_2x2_sched #(.IMG_W(2), .IMG_H(2), .CORE_LAT(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .filter_in(filt2), .busy(busy2),
        .done(done2), .pix_valid(pv2), .pix_ready(pr2), .pix_data(pd2), .core_image(img2),
        .core_filter(fil2), .core_conv_out(core2), .res_valid(rv2), .res_data(rd2),
        .res_last(rl2)
    );

    conv_2x2_sched #(.IMG_W(3), .IMG_H(3), .CORE_LAT(1)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .filter_in(filt3), .busy(busy3),
        .done(done3), .pix_valid(pv3), .pix_ready(pr3), .pix_data(pd3), .core_image(img3),
        .core_filter(fil3), .core_conv_out(core3), .res_valid(rv3), .res_data(rd3),
        .res_last(rl3)
    );

    function automatic logic [15:0] dot(input logic [31:0] im, input logic [31:0] f);
        return 16'(im[31:24]) * 16'(f[31:24]) + 16'(im[23:16]) * 16'(f[23:16])
             + 16'(im[15:8]) * 16'(f[15:8]) + 16'(im[7:0]) * 16'(f[7:0]);
    endfunction

    always_ff @(posedge clk) begin
        core2 <= dot(img2, fil2);
        core3 <= dot(img3, fil3);
    end

    // Result capture and pix_ready watch, sampled mid-cycle.
    logic [15:0] got3[$];
    bit          lst3[$];
    int          res2_cnt  = 0;
    logic [15:0] res2_val  = '0;
    logic        res2_last = 1'b0;
    int          last_cyc2 = -1;
    int          done_cyc2 = -1;
    int          ready_bad = 0;
    bit          feeding3  = 1'b0;

    always @(negedge clk) begin
        if (rv2 === 1'b1) begin
            res2_cnt++;
            res2_val  = rd2;
            res2_last = rl2;
            if (rl2 === 1'b1) last_cyc2 = cyc;
        end
        if (done2 === 1'b1) done_cyc2 = cyc;
        if (rv3 === 1'b1) begin
            got3.push_back(rd3);
            lst3.push_back(rl3 === 1'b1);
        end
        if (pr3 === 1'b1 && !feeding3) ready_bad++;
    end

    task automatic start3_t(input logic [31:0] f, input bit with_pix);
        @(posedge clk); #1;
        start3 = 1'b1;
        filt3  = f;
        if (with_pix) begin
            pv3 = 1'b1;
            pd3 = 8'd99;
        end
        @(posedge clk); #1;
        start3   = 1'b0;
        pv3      = 1'b0;
        feeding3 = 1'b1;
    endtask

    task automatic feed3(input int n, input int base, input int step, input bit gaps,
                         input bit mid_start);
        int guard;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                pv3 = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            pv3 = 1'b1;
            pd3 = 8'(base + step * i);
            if (mid_start && i == 4) begin
                start3 = 1'b1;
                filt3  = '0;
            end
            guard = 0;
            while (pr3 !== 1'b1 && guard < 20) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 20) begin
                total++;
                bad++;
                $display("FAIL feed_ready_timeout pixel=%0d pix_ready=%b required=1", i, pr3);
            end
            @(posedge clk); #1;
            start3 = 1'b0;
        end
        pv3 = 1'b0;
    endtask

    task automatic wait_done3(output int c);
        c = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done3 === 1'b1) begin
                c = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start2 = 0; filt2 = '0; pv2 = 0; pd2 = '0;
        start3 = 0; filt3 = '0; pv3 = 0; pd3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy3, done3, pr3, rv3, rl3} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b required=00000", {busy3, done3, pr3, rv3, rl3});
        end
        total++;
        if ({img3, fil3, rd3} !== 80'h0) begin
            bad++;
            $display("FAIL reset_data img=%h fil=%h res=%h required=0", img3, fil3, rd3);
        end
        total++;
        if ({busy2, done2, pr2, rv2, img2, fil2} !== 68'h0) begin
            bad++;
            $display("FAIL reset_d2 got busy=%b pr=%b img=%h required=0", busy2, pr2, img2);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_window;
        int guard;
        @(posedge clk); #1;
        start2 = 1'b1;
        filt2  = 32'h01020100;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            pv2 = 1'b1;
            pd2 = 8'(i);
            @(posedge clk); #1;
        end
        pv2 = 1'b0;
        guard = 0;
        while (done_cyc2 < 0 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (res2_cnt != 1) begin
            bad++;
            $display("FAIL w2_count got=%0d required=1", res2_cnt);
        end
        total++;
        if (res2_val !== 16'd8 || res2_last !== 1'b1) begin
            bad++;
            $display("FAIL w2_result got=%0d last=%b required=8 last=1", res2_val, res2_last);
        end
        total++;
        if (done_cyc2 < 0 || done_cyc2 != last_cyc2 + 1) begin
            bad++;
            $display("FAIL w2_done_timing done=%0d required=%0d", done_cyc2, last_cyc2 + 1);
        end
    endtask

    task automatic run_3x3(input string tag, input logic [31:0] f, input int base,
                           input int step, input bit gaps, input bit with_pix,
                           input bit mid_start, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
        int c;
        logic [15:0] exp_v[4];
        exp_v = '{e0, e1, e2, e3};
        got3.delete();
        lst3.delete();
        start3_t(f, with_pix);
        feed3(9, base, step, gaps, mid_start);
        feeding3 = 1'b0;
        if (mid_start) begin
            total++;
            if (busy3 !== 1'b1) begin
                bad++;
                $display("FAIL %s busy_after_start got=%b required=1", tag, busy3);
            end
        end
        wait_done3(c);
        total++;
        if (c < 0) begin
            bad++;
            $display("FAIL %s done_timeout got=none required=pulse", tag);
        end
        total++;
        if (got3.size() != 4) begin
            bad++;
            $display("FAIL %s count got=%0d required=4", tag, got3.size());
        end
        for (int i = 0; i < 4 && i < got3.size(); i++) begin
            total++;
            if (got3[i] !== exp_v[i] || lst3[i] != (i == 3)) begin
                bad++;
                $display("FAIL %s res%0d got=%0d last=%b required=%0d last=%b", tag, i,
                         got3[i], lst3[i], exp_v[i], (i == 3));
            end
        end
        @(negedge clk);
        total++;
        if (done3 !== 1'b0 || busy3 !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done got done=%b busy=%b required=0 0", tag, done3, busy3);
        end
    endtask

    task automatic test_frame_basic;
        run_3x3("basic", 32'h01010101, 1, 1, 1'b0, 1'b0, 1'b0, 16'd12, 16'd16, 16'd24, 16'd28);
    endtask

    task automatic test_gaps;
        ready_bad = 0;
        run_3x3("gaps", 32'h01010101, 1, 1, 1'b1, 1'b1, 1'b0, 16'd12, 16'd16, 16'd24, 16'd28);
        total++;
        if (ready_bad != 0) begin
            bad++;
            $display("FAIL ready_outside_run got=%0d cycles required=0", ready_bad);
        end
    endtask

    task automatic test_start_while_busy;
        run_3x3("midstart", 32'h01010101, 1, 1, 1'b0, 1'b0, 1'b1,
                16'd12, 16'd16, 16'd24, 16'd28);
    endtask

    task automatic test_reset_mid_frame;
        got3.delete();
        lst3.delete();
        start3_t(32'h01010101, 1'b0);
        feed3(5, 1, 1, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        feeding3 = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        total++;
        if ({busy3, pr3, rv3, done3} !== 4'b0 || img3 !== '0 || fil3 !== '0) begin
            bad++;
            $display("FAIL midreset_outputs got busy=%b pr=%b rv=%b img=%h required=0",
                     busy3, pr3, rv3, img3);
        end
        repeat (10) @(negedge clk);
        total++;
        if (got3.size() != 0) begin
            bad++;
            $display("FAIL midreset_dropped got=%0d results required=0", got3.size());
        end
        test_frame_basic();
    endtask

    task automatic test_back_to_back;
        run_3x3("b2b_f1", 32'h01000001, 1, 1, 1'b0, 1'b0, 1'b0, 16'd6, 16'd8, 16'd12, 16'd14);
        run_3x3("b2b_f2", 32'h01000001, 9, -1, 1'b0, 1'b0, 1'b0,
                16'd14, 16'd12, 16'd8, 16'd6);
    endtask

    initial begin
        test_reset();
        test_single_window();
        test_frame_basic();
        test_gaps();
        test_start_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
